line_rx: RTL and testbench
==========================

LINE_RX -- requirements
Module: line_rx

Interface
REQ-001 Parameter OVS, default 16, oversampling ticks per bit time; legal values are even integers 8..32.
REQ-002 i_clk  input  1  system clock; all logic is on its rising edge.
REQ-003 i_rst  input  1  reset; asynchronous, active-high, one clock domain only.
REQ-004 i_clk_rx  input  1  oversampling enable, one i_clk cycle wide, OVS pulses per bit time.
REQ-005 i_rx_data  input  1  serial line from the line_tx output; asynchronous to i_clk; idle level 1.
REQ-006 i_parity  input  2  parity mode: 2'b00 even, 2'b01 odd, 2'b10 none, 2'b11 none.
REQ-007 o_rx_data  output  8  received byte, LSB first on the line.
REQ-008 o_rx_valid  output  1  one-i_clk-cycle pulse marking a completed frame.
REQ-009 o_parity_err  output  1  parity mismatch for the frame flagged by o_rx_valid.
REQ-010 o_frame_err  output  1  stop-bit error for the frame flagged by o_rx_valid.
REQ-011 o_rx_busy  output  1  high from start-bit detection until the frame ends or is aborted.

Function
REQ-012 The block SHALL pass i_rx_data through a 2-flop synchronizer; all further logic uses the synchronized bit.
REQ-013 Frame format: start 0, d[0]..d[7], parity slot, stop 1. In none mode the parity slot is not checked and the stop bit is sampled in that slot.
REQ-014 States: IDLE, START, DATA, PARITY, STOP. All transitions occur only on i_clk edges where i_clk_rx=1.
REQ-015 IDLE -> START when an armed receiver sees a synchronized 0; the tick counter clears to 0.
REQ-016 The armed flag SHALL set on a synchronized 1 in IDLE and clear on leaving IDLE, so a held-low line (break) never starts a second frame.
REQ-017 Each bit SHALL be sampled at ticks OVS/2-1, OVS/2 and OVS/2+1, and its value is the 2-of-3 majority of those samples.
REQ-018 START: majority 1 at tick OVS/2+1 is a false start -> IDLE with no valid pulse; majority 0 -> DATA at tick OVS-1.
REQ-019 DATA: bit index 0..7; each majority bit shifts into bit[index]; after index 7 at tick OVS-1 go to PARITY, or to STOP in none mode.
REQ-020 i_parity SHALL be captured when the start bit is confirmed; changes during a frame have no effect.
REQ-021 Parity check: even mode expects slot = XNOR-reduce(data) and odd mode expects slot = XOR-reduce(data); a mismatch sets the parity-error flag.
REQ-022 STOP: at tick OVS/2+1 the majority is taken, the FSM returns to IDLE (unarmed), and on the next i_clk edge o_rx_valid=1, o_rx_data=shift register, o_frame_err=(majority==0), o_parity_err=flag.
REQ-023 o_rx_data and both error outputs SHALL hold their values until the next o_rx_valid; errors are 0 in none mode (parity) and are never sticky across frames.
REQ-024 Frame completes mid-stop-bit so that back-to-back line_tx frames, including the 11-bit-time none-mode frame, are received with no loss.
REQ-025 The tick counter wraps OVS-1 -> 0 at each bit boundary; no counter exceeds OVS-1 or bit index 7.

Reset
REQ-026 Reset SHALL force: state IDLE, armed 0, synchronizer flops 1, o_rx_data 8'h00, o_rx_valid 0, o_parity_err 0, o_frame_err 0, o_rx_busy 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no valid pulse; after release the block needs a line 1 before it accepts a start.

Structure
REQ-028 Shared package line_pkg SHALL hold the parity-mode constants (P_EVEN, P_ODD, P_NONE) and the RX state encoding, for use by line_tx and line_rx.
REQ-029 Sub-module line_rx_sample SHALL contain the synchronizer and 3-sample majority voter; the FSM and datapath stay in line_rx.

Verification
REQ-030 line_tx drives 8'hA5 in even mode, OVS=16 -> one valid pulse with o_rx_data=8'hA5 and both error outputs 0.
REQ-031 Back-to-back frames 8'h00, 8'hFF, 8'h3C in none mode -> three valid pulses with the data in that order and no errors.
REQ-032 A 5-tick low glitch on an idle line -> no valid pulse, o_rx_busy returns to 0, and a following 8'h55 frame is received correctly.
REQ-033 Odd mode with the parity bit inverted on 8'h81 -> o_rx_data=8'h81 and o_parity_err=1; the next clean frame shows o_parity_err=0.
REQ-034 Stop bit forced to 0 on 8'h7E, then line held low for 30 bit times -> o_frame_err=1, a single valid pulse, and no further frames until the line returns high.
REQ-035 Reset pulsed during data bit 4 -> outputs at reset values and no valid pulse; a following 8'hC3 frame is received correctly.

Source files
------------

// File: rtl/line_pkg.sv
// Shared definitions for the line_tx / line_rx serial pair: parity modes,
// receiver state encoding and the parity-slot rule both ends agree on.
package line_pkg;

    localparam logic [1:0] P_EVEN = 2'b00;
    localparam logic [1:0] P_ODD  = 2'b01;
    localparam logic [1:0] P_NONE = 2'b10;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;

    // Both 2'b10 and 2'b11 mean "no parity slot check".
    function automatic logic parity_none(input logic [1:0] mode);
        return mode[1];
    endfunction

    // Even mode carries XNOR-reduce of the data, odd mode XOR-reduce.
    function automatic logic parity_slot(input logic [7:0] data, input logic [1:0] mode);
        return mode[0] ? (^data) : (~^data);
    endfunction

endpackage

// File: rtl/line_rx_sample.sv
// Input synchronizer and mid-bit 3-sample majority voter for line_rx.
module line_rx_sample #(
    parameter int OVS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_rx,
    input  logic                     rx_in,
    input  logic [$clog2(OVS)-1:0]   tick,
    output logic                     rx_sync,
    output logic                     majority
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] T_EARLY = TW'(OVS/2 - 1);
    localparam logic [TW-1:0] T_MID   = TW'(OVS/2);

    logic sync_p0;
    logic sync_p1;
    logic s_early;
    logic s_mid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= rx_in;
            sync_p1 <= sync_p0;
        end
    end

    assign rx_sync = sync_p1;

    // The third vote is the live synchronized bit at tick OVS/2+1.
    always_ff @(posedge clk) begin
        if (clk_rx) begin
            if (tick == T_EARLY) s_early <= rx_sync;
            if (tick == T_MID)   s_mid   <= rx_sync;
        end
    end

    assign majority = (s_early & s_mid) | (s_early & rx_sync) | (s_mid & rx_sync);

endmodule

// File: rtl/line_rx.sv
// Oversampling UART-style receiver: start/8 data/parity slot/stop, majority
// voted bits, frame completes mid-stop-bit so back-to-back frames are not lost.
module line_rx
    import line_pkg::*;
#(
    parameter int OVS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clk_rx,
    input  logic       i_rx_data,
    input  logic [1:0] i_parity,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_rx_busy
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] T_VOTE = TW'(OVS/2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);

    logic [2:0]    state;
    logic          armed;
    logic [TW-1:0] tick;
    logic [2:0]    bit_idx;
    logic [1:0]    mode;
    logic          par_err;
    logic          stop_bit;
    logic          done_p0;
    logic [7:0]    shift;
    logic          rx_sync;
    logic          majority;

    line_rx_sample #(.OVS(OVS)) u_sample (
        .clk      (i_clk),
        .rst      (i_rst),
        .clk_rx   (i_clk_rx),
        .rx_in    (i_rx_data),
        .tick     (tick),
        .rx_sync  (rx_sync),
        .majority (majority)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= RX_IDLE;
            armed     <= 1'b0;
            tick      <= '0;
            bit_idx   <= '0;
            mode      <= P_EVEN;
            par_err   <= 1'b0;
            stop_bit  <= 1'b1;
            done_p0   <= 1'b0;
            o_rx_busy <= 1'b0;
        end else begin
            done_p0 <= 1'b0;
            if (i_clk_rx) begin
                tick <= (tick == T_LAST) ? '0 : tick + TW'(1);
                case (state)
                    RX_IDLE: begin
                        tick <= '0;
                        // Arming on a seen 1 keeps a held-low break from retriggering.
                        if (armed && !rx_sync) begin
                            state     <= RX_START;
                            armed     <= 1'b0;
                            o_rx_busy <= 1'b1;
                        end else if (rx_sync) begin
                            armed <= 1'b1;
                        end
                    end
                    RX_START: begin
                        if (tick == T_VOTE) begin
                            if (majority) begin
                                state     <= RX_IDLE;
                                o_rx_busy <= 1'b0;
                            end else begin
                                mode    <= i_parity;
                                par_err <= 1'b0;
                            end
                        end else if (tick == T_LAST) begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end
                    end
                    RX_DATA: begin
                        if (tick == T_LAST) begin
                            if (bit_idx == 3'd7) begin
                                state <= parity_none(mode) ? RX_STOP : RX_PARITY;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (tick == T_VOTE) begin
                            par_err <= (majority != parity_slot(shift, mode));
                        end else if (tick == T_LAST) begin
                            state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (tick == T_VOTE) begin
                            state     <= RX_IDLE;
                            o_rx_busy <= 1'b0;
                            stop_bit  <= majority;
                            done_p0   <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= RX_IDLE;
                        o_rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clk_rx && state == RX_DATA && tick == T_VOTE) begin
            shift[bit_idx] <= majority;
        end
    end

    // Result stage: one cycle after the stop vote.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rx_valid   <= 1'b0;
            o_rx_data    <= 8'h00;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_rx_valid <= done_p0;
            if (done_p0) begin
                o_rx_data    <= shift;
                o_parity_err <= par_err;
                o_frame_err  <= ~stop_bit;
            end
        end
    end

endmodule

// File: tb/tb_line_rx.sv
// Directed testbench for line_rx: a behavioural line transmitter drives frames
// and a negedge monitor logs every valid pulse for the scenario tasks to check.
module tb_line_rx;
    import line_pkg::*;

    localparam int OVS    = 16;
    localparam int CE_DIV = 4;
    localparam int BIT    = OVS * CE_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_rx = 1'b0;
    logic       rx_line = 1'b1;
    logic [1:0] parity = 2'b00;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] log_data [0:31];
    logic       log_perr [0:31];
    logic       log_ferr [0:31];

    line_rx #(.OVS(OVS)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clk_rx     (clk_rx),
        .i_rx_data    (rx_line),
        .i_parity     (parity),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .o_parity_err (parity_err),
        .o_frame_err  (frame_err),
        .o_rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (CE_DIV - 1) @(negedge clk);
            clk_rx = 1'b1;
            @(negedge clk);
            clk_rx = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_busy) busy_cnt++;
        if (rx_valid) begin
            log_data[vld_cnt % 32] = rx_data;
            log_perr[vld_cnt % 32] = parity_err;
            log_ferr[vld_cnt % 32] = frame_err;
            if (parity_err || frame_err) err_cnt++;
            vld_cnt++;
        end
    end

    task automatic send_bit(input logic b);
        rx_line = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx_line = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    // Always 11 bit times; in none mode the slot carries a 1.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] m,
                              input logic flip, input logic stop);
        int   ones;
        logic slot;
        ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        if (m[1])      slot = 1'b1;
        else if (m[0]) slot = (ones % 2 == 1);
        else           slot = (ones % 2 == 0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(slot ^ flip);
        send_bit(stop);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        rst = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_even_a5();
        int base;
        base = vld_cnt;
        parity = P_EVEN;
        send_frame(8'hA5, P_EVEN, 1'b0, 1'b1);
        idle_bits(1);
        checks++; if (vld_cnt - base != 1) begin errors++; $display("FAIL a5_count: got %0d want 1", vld_cnt - base); end
        checks++; if (log_data[base % 32] !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", log_data[base % 32]); end
        checks++; if (log_perr[base % 32] !== 1'b0) begin errors++; $display("FAIL a5_perr: got %b want 0", log_perr[base % 32]); end
        checks++; if (log_ferr[base % 32] !== 1'b0) begin errors++; $display("FAIL a5_ferr: got %b want 0", log_ferr[base % 32]); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL a5_hold: got %h want a5", rx_data); end
    endtask

    task automatic test_back_to_back();
        int base;
        int ebase;
        logic [7:0] exp [0:2];
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
        base  = vld_cnt;
        ebase = err_cnt;
        parity = P_NONE;
        for (int i = 0; i < 3; i++) send_frame(exp[i], P_NONE, 1'b0, 1'b1);
        idle_bits(1);
        checks++; if (vld_cnt - base != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", vld_cnt - base); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_data[(base + i) % 32] !== exp[i]) begin
                errors++; $display("FAIL b2b_data%0d: got %h want %h", i, log_data[(base + i) % 32], exp[i]);
            end
        end
        checks++; if (err_cnt - ebase != 0) begin errors++; $display("FAIL b2b_errors: got %0d want 0", err_cnt - ebase); end
    endtask

    task automatic test_glitch();
        int base;
        int bbase;
        parity = P_EVEN;
        idle_bits(1);
        base  = vld_cnt;
        bbase = busy_cnt;
        rx_line = 1'b0;
        repeat (5 * CE_DIV) @(negedge clk);
        idle_bits(2);
        checks++; if (busy_cnt - bbase == 0) begin errors++; $display("FAIL glitch_busy_seen: got 0 busy cycles want >0"); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", rx_busy); end
        checks++; if (vld_cnt - base != 0) begin errors++; $display("FAIL glitch_count: got %0d want 0", vld_cnt - base); end
        send_frame(8'h55, P_EVEN, 1'b0, 1'b1);
        idle_bits(1);
        checks++; if (vld_cnt - base != 1) begin errors++; $display("FAIL glitch_55_count: got %0d want 1", vld_cnt - base); end
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL glitch_55_data: got %h want 55", rx_data); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL glitch_55_perr: got %b want 0", parity_err); end
    endtask

    task automatic test_parity_odd();
        int base;
        base = vld_cnt;
        parity = P_ODD;
        send_frame(8'h81, P_ODD, 1'b1, 1'b1);
        idle_bits(1);
        checks++; if (vld_cnt - base != 1) begin errors++; $display("FAIL odd_count: got %0d want 1", vld_cnt - base); end
        checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL odd_data: got %h want 81", rx_data); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL odd_perr: got %b want 1", parity_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL odd_ferr: got %b want 0", frame_err); end
        send_frame(8'h42, P_ODD, 1'b0, 1'b1);
        idle_bits(1);
        checks++; if (rx_data !== 8'h42) begin errors++; $display("FAIL odd_clean_data: got %h want 42", rx_data); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL odd_clean_perr: got %b want 0", parity_err); end
    endtask

    task automatic test_break();
        int base;
        base = vld_cnt;
        parity = P_EVEN;
        send_frame(8'h7E, P_EVEN, 1'b0, 1'b0);
        rx_line = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        checks++; if (vld_cnt - base != 1) begin errors++; $display("FAIL break_count: got %0d want 1", vld_cnt - base); end
        checks++; if (rx_data !== 8'h7E) begin errors++; $display("FAIL break_data: got %h want 7e", rx_data); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b want 1", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL break_perr: got %b want 0", parity_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_busy: got %b want 0", rx_busy); end
        idle_bits(3);
        checks++; if (vld_cnt - base != 1) begin errors++; $display("FAIL break_after_count: got %0d want 1", vld_cnt - base); end
    endtask

    task automatic test_reset_mid();
        int base;
        logic [7:0] d;
        d = 8'h96;
        base = vld_cnt;
        parity = P_EVEN;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_line = d[4];
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_ferr: got %b want 0", frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", rx_busy); end
        rst = 1'b0;
        idle_bits(12);
        checks++; if (vld_cnt - base != 0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", vld_cnt - base); end
        send_frame(8'hC3, P_EVEN, 1'b0, 1'b1);
        idle_bits(1);
        checks++; if (vld_cnt - base != 1) begin errors++; $display("FAIL rstmid_c3_count: got %0d want 1", vld_cnt - base); end
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL rstmid_c3_data: got %h want c3", rx_data); end
        checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_c3_err: got p=%b f=%b want 0 0", parity_err, frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_even_a5();
        test_back_to_back();
        test_glitch();
        test_parity_odd();
        test_break();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
